// File: rtl/bin2gray_pkg.sv
// Shared constants and FSM state encoding for the Gray-code sweep generator.
package bin2gray_pkg;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned SWEEP_LEN = 2 ** WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter; inverse of graytobin.
module bin2gray #(
  parameter int unsigned WIDTH = bin2gray_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray_c
);

  // MSB passes through; every lower bit is the XOR with its upper neighbour.
  always_comb begin
    gray_c = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/bin2gray_sweep.sv
// Walks a binary counter through one full wrap from a start value and emits
// each value as registered Gray code, followed by a one-cycle done pulse.
module bin2gray_sweep #(
  parameter int unsigned WIDTH = bin2gray_pkg::WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic dir,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  output logic G3,
  output logic G2,
  output logic G1,
  output logic G0,
  output logic valid,
  output logic busy,
  output logic done
);

  import bin2gray_pkg::*;

  localparam int unsigned     LEN    = 2 ** WIDTH;
  localparam logic [WIDTH-1:0] LAST_N = WIDTH'(LEN - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] gray_next_c;
  logic [WIDTH-1:0] b_in;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign b_in = WIDTH'({B3, B2, B1, B0});

  // Next-state, counter and flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = b_in;
          dir_d   = dir;
          n_d     = '0;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (n_q == LAST_N) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = dir_q ? (cnt_q - ONE) : (cnt_q + ONE);
          n_d     = n_q + ONE;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Converting cnt_d keeps output latency at one cycle and cnt_q aligned with G.
  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin    (cnt_d),
    .gray_c (gray_next_c)
  );

  // G only updates with a new element; it holds through DONE and IDLE.
  always_comb begin
    g_d = g_q;
    if (valid_d) begin
      g_d = gray_next_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      dir_q   <= 1'b0;
      g_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      dir_q   <= dir_d;
      g_q     <= g_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign G3    = g_q[3];
  assign G2    = g_q[2];
  assign G1    = g_q[1];
  assign G0    = g_q[0];
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bin2gray_sweep.sv
// Randomized and directed bench for bin2gray_sweep against a reflected-code
// reference table and a graytobin loop-back decoder.
module tb_bin2gray_sweep;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic dir;
  logic B3, B2, B1, B0;
  logic G3, G2, G1, G0;
  logic valid, busy, done;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] gtab [16];

  always #5 clk = ~clk;

  bin2gray_sweep #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dir   (dir),
    .B3    (B3),
    .B2    (B2),
    .B1    (B1),
    .B0    (B0),
    .G3    (G3),
    .G2    (G2),
    .G1    (G1),
    .G0    (G0),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] g_out();
    return {G3, G2, G1, G0};
  endfunction

  task automatic scramble_inputs();
    dir = 1'($urandom_range(0, 1));
    {B3, B2, B1, B0} = 4'($urandom_range(0, 15));
  endtask

  // Entered and left at 1 time unit after a rising edge with the FSM in IDLE.
  // poke 0..15 pulses start in that RUN cycle, 16 pulses it in DONE, else none.
  task automatic do_sweep(input logic [3:0] b, input logic d, input int poke);
    logic [3:0] prev_g;
    logic [3:0] exp_bin;
    int         cur;
    start = 1'b1;
    dir   = d;
    {B3, B2, B1, B0} = b;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    prev_g = '0;
    exp_bin = b;
    for (int k = 0; k < 16; k++) begin
      cur = d ? (int'(b) - k + 16) % 16 : (int'(b) + k) % 16;
      exp_bin = 4'(cur);
      chk("valid", int'(valid), 1);
      chk("busy", int'(busy), 1);
      chk("done_run", int'(done), 0);
      chk("gray", int'(g_out()), int'(gtab[cur]));
      chk("loopback", int'(gray2bin(g_out())), cur);
      if (k > 0) chk("hamming", $countones(prev_g ^ g_out()), 1);
      prev_g = g_out();
      if (k == poke) begin
        start = 1'b1;
        scramble_inputs();
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_pulse", int'(done), 1);
    chk("valid_done", int'(valid), 0);
    chk("busy_done", int'(busy), 1);
    chk("hold_done", int'(g_out()), int'(gtab[exp_bin]));
    if (poke == 16) begin
      start = 1'b1;
      scramble_inputs();
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_idle", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("valid_idle", int'(valid), 0);
    chk("hold_idle", int'(g_out()), int'(gtab[exp_bin]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reflect-and-prefix construction of the 4-bit Gray sequence.
    gtab[0] = 4'd0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < (1 << k); i++)
        gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | 4'(1 << k);

    rst = 1'b1;
    start = 1'b0;
    dir = 1'b0;
    {B3, B2, B1, B0} = 4'd0;
    #2;
    chk("rst_g", int'(g_out()), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First edge after reset release must accept start; sweeps chain back to back.
    do_sweep(4'b0000, 1'b0, -1);
    do_sweep(4'b1110, 1'b0, -1);
    do_sweep(4'b0001, 1'b1, -1);
    do_sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4);
    do_sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16);

    // Asynchronous reset in the middle of a sweep.
    start = 1'b1;
    dir = 1'b0;
    {B3, B2, B1, B0} = 4'b0011;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_valid", int'(valid), 1);
    rst = 1'b1;
    #1;
    chk("abort_g", int'(g_out()), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done), 0);
      chk("abort_no_valid", int'(valid), 0);
    end
    rst = 1'b0;
    do_sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);

    for (int r = 0; r < 10; r++) begin
      int p;
      p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : -1;
      do_sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), p);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("idle_gap_valid", int'(valid), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
